// File: rtl/cory_pkg.sv
// cory_pkg: shared state encoding, port index width and rotate-priority search for cory arbiters
package cory_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam int PW = 2;
  function automatic logic [PW:0] next_valid(input logic [3:0] valid, input logic [PW-1:0] ptr);
    logic [PW:0] r;
    r = {1'b0, ptr};
    for (int i = 3; i >= 0; i--)
      if (valid[PW'(ptr + PW'(i))]) r = {1'b1, PW'(ptr + PW'(i))};
    return r;
  endfunction
endpackage

// File: rtl/cory_wrr4_if.sv
// cory_wrr4_if: four valid/ready/last producer ports, weights and the merged output channel
interface cory_wrr4_if #(parameter int N = 8, parameter int W = 4);
  logic i_a0_v, i_a1_v, i_a2_v, i_a3_v;
  logic i_a0_l, i_a1_l, i_a2_l, i_a3_l;
  logic [N-1:0] i_a0_d, i_a1_d, i_a2_d, i_a3_d;
  logic o_a0_r, o_a1_r, o_a2_r, o_a3_r;
  logic [4*W-1:0] i_wgt;
  logic o_z_v, o_z_l, i_z_r;
  logic [N-1:0] o_z_d;
  logic [1:0] o_z_s;
  modport slave(
    input i_a0_v, i_a1_v, i_a2_v, i_a3_v, i_a0_l, i_a1_l, i_a2_l, i_a3_l,
    input i_a0_d, i_a1_d, i_a2_d, i_a3_d, i_wgt, i_z_r,
    output o_a0_r, o_a1_r, o_a2_r, o_a3_r, o_z_v, o_z_l, o_z_d, o_z_s
  );
  modport master(
    output i_a0_v, i_a1_v, i_a2_v, i_a3_v, i_a0_l, i_a1_l, i_a2_l, i_a3_l,
    output i_a0_d, i_a1_d, i_a2_d, i_a3_d, i_wgt, i_z_r,
    input o_a0_r, o_a1_r, o_a2_r, o_a3_r, o_z_v, o_z_l, o_z_d, o_z_s
  );
endinterface

// File: rtl/cory_wrr4_rr_pick4.sv
// cory_rr_pick4: combinational 4-way rotate-priority picker; sel falls back to ptr when nothing is valid
module cory_rr_pick4
  import cory_pkg::*;
(
  input  logic [3:0]    valid,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any
);
  assign {any, sel} = next_valid(valid, ptr);
endmodule

// File: rtl/cory_wrr4.sv
// cory_wrr4: 4-input weighted round-robin packet scheduler; CORY_WRR4_AGE_EN adds starvation age override
module cory_wrr4
  import cory_pkg::*;
#(
  parameter int N   = 8,
  parameter int W   = 4,
  parameter int AGE = 8
) (
  input logic        clk,
  input logic        reset_n,
  cory_wrr4_if.slave bus
);
  state_t fsm, fsm_n;
  logic [PW-1:0] gnt, gnt_n, ptr, ptr_n, sel, rr_sel;
  logic [W-1:0] cnt, cnt_n, wgt, credit;
  logic [3:0] v, l, rdy;
  logic [N-1:0] d [4];
  logic any, zv, xfer, start, reload;
  assign v = {bus.i_a3_v, bus.i_a2_v, bus.i_a1_v, bus.i_a0_v};
  assign l = {bus.i_a3_l, bus.i_a2_l, bus.i_a1_l, bus.i_a0_l};
  assign d = '{bus.i_a0_d, bus.i_a1_d, bus.i_a2_d, bus.i_a3_d};
  cory_rr_pick4 u_pick (.valid(v), .ptr(ptr), .sel(rr_sel), .any(any));
`ifdef CORY_WRR4_AGE_EN
  logic [AGE-1:0] age [4];
  logic [3:0] sat;
  logic [PW-1:0] age_sel;
  always_comb begin
    sat = '0;
    age_sel = '0;
    for (int k = 3; k >= 0; k--) begin
      sat[k] = v[k] & (&age[k]);
      if (sat[k]) age_sel = PW'(k);
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      age[k] <= (!reset_n || (xfer && sel == PW'(k))) ? '0 : age[k] + AGE'(v[k] & ~&age[k]);
  assign sel = fsm == LOCK ? gnt : |sat ? age_sel : rr_sel;
`else
  logic unused_age;
  assign unused_age = AGE[0] ^ any;
  assign sel = fsm == LOCK ? gnt : rr_sel;
`endif
  // sel is independent of i_z_r so the output holds steady under backpressure
  assign zv = reset_n & v[sel];
  assign xfer = zv & bus.i_z_r;
  assign rdy = {4{reset_n & bus.i_z_r}} & (4'b1 << sel);
  assign wgt = bus.i_wgt[W*sel +: W];
  assign start = xfer && fsm == IDLE;
  assign reload = start && (sel != ptr || cnt == '0);
  assign credit = !reload ? cnt : wgt == '0 ? W'(1) : wgt;
  always_comb begin
    fsm_n = fsm;
    gnt_n = gnt;
    ptr_n = ptr;
    cnt_n = cnt;
    if (start && !l[sel]) begin
      fsm_n = LOCK;
      gnt_n = sel;
    end
    if (reload) begin
      ptr_n = sel;
      cnt_n = credit;
    end
    if (xfer && l[sel]) begin
      fsm_n = IDLE;
      ptr_n = credit <= W'(1) ? sel + 1'b1 : sel;
      cnt_n = credit <= W'(1) ? '0 : credit - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      fsm <= IDLE;
      gnt <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_n;
      gnt <= gnt_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  assign bus.o_z_v = zv;
  assign bus.o_z_d = d[sel];
  assign bus.o_z_l = l[sel];
  assign bus.o_z_s = sel;
  assign {bus.o_a3_r, bus.o_a2_r, bus.o_a1_r, bus.o_a0_r} = rdy;
endmodule

// File: tb/tb_cory_wrr4.sv
// tb_cory_wrr4: randomized and directed bench for cory_wrr4 against a turn/credit behavioural model
module tb_cory_wrr4;
  localparam int N = 8, W = 4, AGE = 8;
  logic clk = 0, reset_n = 0, zr = 0;
  logic [3:0] v = 0, l = 0, ar;
  logic [N-1:0] d [4];
  logic [4*W-1:0] wgt = 0;
  bit [3:0] xf;
  int checks = 0, failures = 0;
  int m_gnt, m_ptr, m_cred, m_age [4];
  bit m_lock;
  int bc [4], plen [4];
  int log_s[$], exp_q[$];
  always #5 clk = ~clk;
  cory_wrr4_if #(.N(N), .W(W)) bus();
  cory_wrr4 #(.N(N), .W(W), .AGE(AGE)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  assign {bus.i_a3_v, bus.i_a2_v, bus.i_a1_v, bus.i_a0_v} = v;
  assign {bus.i_a3_l, bus.i_a2_l, bus.i_a1_l, bus.i_a0_l} = l;
  assign bus.i_a0_d = d[0];
  assign bus.i_a1_d = d[1];
  assign bus.i_a2_d = d[2];
  assign bus.i_a3_d = d[3];
  assign bus.i_wgt = wgt;
  assign bus.i_z_r = zr;
  assign ar = {bus.o_a3_r, bus.o_a2_r, bus.o_a1_r, bus.o_a0_r};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_seq(string name);
    chk({name, "_len"}, log_s.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_s.size(); i++) chk(name, log_s[i], exp_q[i]);
  endtask

  // model: one packet at a time; the turn owner spends its packet credit, then the turn passes on
  task automatic check_cycle();
    int es, w;
    bit ev, aged;
    @(negedge clk);
    xf = '0;
    if (!reset_n) begin
      chk("rst_z_v", bus.o_z_v, 0);
      chk("rst_ready", ar, 0);
      m_lock = 0; m_gnt = 0; m_ptr = 0; m_cred = 0;
      for (int k = 0; k < 4; k++) m_age[k] = 0;
      return;
    end
    ev = 0;
    es = m_ptr;
    if (m_lock) begin
      es = m_gnt;
      ev = v[m_gnt];
    end else begin
      for (int i = 0; i < 4; i++)
        if (!ev && v[(m_ptr + i) % 4]) begin es = (m_ptr + i) % 4; ev = 1; end
      aged = 0;
`ifdef CORY_WRR4_AGE_EN
      for (int k = 0; k < 4; k++)
        if (!aged && v[k] && m_age[k] == (1 << AGE) - 1) begin es = k; aged = 1; end
`endif
    end
    chk("z_v", bus.o_z_v, ev);
    chk("z_s", bus.o_z_s, es);
    chk("ready", ar, zr ? (1 << es) : 0);
    if (ev) begin
      chk("z_d", bus.o_z_d, d[es]);
      chk("z_l", bus.o_z_l, l[es]);
    end
    if (bus.o_z_v && zr) log_s.push_back(bus.o_z_s);
    if (ev && zr) xf[es] = 1;
    for (int k = 0; k < 4; k++) m_age[k] = xf[k] ? 0 : (v[k] && m_age[k] < (1 << AGE) - 1) ? m_age[k] + 1 : m_age[k];
    if (!(ev && zr)) return;
    if (!m_lock) begin
      if (es != m_ptr || m_cred == 0) begin
        w = (wgt >> (es * W)) % (1 << W);
        m_ptr = es;
        m_cred = (w == 0) ? 1 : w;
      end
      if (!l[es]) begin m_lock = 1; m_gnt = es; end
    end
    if (l[es]) begin
      m_lock = 0;
      if (m_cred <= 1) begin m_ptr = (es + 1) % 4; m_cred = 0; end
      else m_cred--;
    end
  endtask

  task automatic dcyc();
    check_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (xf[k]) d[k] = N'($urandom);
  endtask

  task automatic rcyc();
    check_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (xf[k]) begin
        if (l[k]) begin bc[k] = 0; plen[k] = $urandom_range(1, 4); end
        else bc[k]++;
      end
      if (xf[k] || !v[k]) begin
        v[k] = $urandom_range(0, 2) != 0;
        d[k] = N'($urandom);
        l[k] = bc[k] == plen[k] - 1;
      end
    end
    zr = $urandom_range(0, 3) != 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    dcyc();
    reset_n = 1;
    log_s.delete();
  endtask

  initial begin
    logic [N-1:0] dstall;
    for (int k = 0; k < 4; k++) begin d[k] = N'($urandom); bc[k] = 0; plen[k] = 1; end
    // all ports streaming single-beat packets, weights 3,1,1,1
    wgt = {4'd1, 4'd1, 4'd1, 4'd3};
    v = 4'hF; l = 4'hF; zr = 1;
    do_reset();
    do_reset();
    for (int i = 0; i < 12; i++) dcyc();
    exp_q = {0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
    chk_seq("wrr_seq");
    // port 1 four-beat packet with a 5-cycle stall, port 0 contending
    do_reset();
    v = 4'b0010; l = 4'b0000;
    dcyc();
    v = 4'b0011; l = 4'b0001;
    dcyc();
    dcyc();
    zr = 0;
    dstall = d[1];
    for (int i = 0; i < 5; i++) begin
      dcyc();
      chk("stall_s", bus.o_z_s, 1);
      chk("stall_d", bus.o_z_d, dstall);
      chk("stall_a0_r", bus.o_a0_r, 0);
    end
    zr = 1; l = 4'b0011;
    dcyc();
    v = 4'b0001;
    dcyc();
    exp_q = {1, 1, 1, 1, 0};
    chk_seq("pkt_seq");
    // port 2 idles after one packet, port 3 takes over with its own credit
    wgt = {4'd3, 4'd2, 4'd1, 4'd1};
    v = 4'b0000; l = 4'hF;
    do_reset();
    v = 4'b0100;
    dcyc();
    v = 4'b1000;
    dcyc();
    v = 4'b1100;
    for (int i = 0; i < 5; i++) dcyc();
    exp_q = {2, 3, 3, 3, 2, 2, 3};
    chk_seq("forfeit_seq");
    // reset while locked on port 3
    v = 4'b0000;
    do_reset();
    v = 4'b1000; l = 4'b0000;
    dcyc();
    v = 4'b1001;
    dcyc();
    chk("lock_s", bus.o_z_s, 3);
    reset_n = 0;
    #1;
    chk("lock_rst_v", bus.o_z_v, 0);
    dcyc();
    reset_n = 1;
    #1;
    chk("post_rst_v", bus.o_z_v, 1);
    chk("post_rst_s", bus.o_z_s, 0);
    dcyc();
    // randomized traffic, backpressure and weights
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) wgt = 16'($urandom);
      rcyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
